// File: rtl/shift_seq.sv
// Iterative 16-bit shift/rotate (ROL/SLL/ROR/SRL): one log-shifter stage of 1/2/4/8 per clock.
// Latency: popcount(cnt)+1 cycles from accepted start to the done pulse (1..5).
// Backpressure: ready=0 while shifting; start is ignored in that window, and is accepted back-to-back in the done cycle.
//
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst   - synchronous active-low reset
//   start - request, honoured only while ready=1
//   in    - 16-bit operand, captured on an accepted start
//   cnt   - 4-bit shift amount, captured on an accepted start
//   op    - 00 ROL, 01 SLL, 10 ROR, 11 SRL, captured on an accepted start
//   out   - result register; updates only on DONE entry and on reset
//   done  - one-cycle pulse, out is new and valid while high
//   ready - high in IDLE and DONE
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic [15:0] out,
  output logic        done,
  output logic        ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_work;
  logic [3:0]  r_rem;
  logic [1:0]  r_op_q;

  logic [3:0]  w_amt;       // lowest set bit of r_rem, isolated; its value is the stage amount 1/2/4/8
  logic [4:0]  w_inv;       // 16 - amount, the wrap-around distance for rotates
  logic [3:0]  w_rem_next;
  logic [15:0] w_shifted;

  always_comb begin
    w_amt      = r_rem & (~r_rem + 4'd1);
    w_inv      = 5'd16 - {1'b0, w_amt};
    w_rem_next = r_rem & ~w_amt;
    w_shifted  = r_work;
    case (r_op_q)
      2'b00:   w_shifted = (r_work << w_amt) | (r_work >> w_inv);
      2'b01:   w_shifted = r_work << w_amt;
      2'b10:   w_shifted = (r_work >> w_amt) | (r_work << w_inv);
      default: w_shifted = r_work >> w_amt;
    endcase
  end

  // done/ready are pure state decode, so there is no input-to-output path.
  assign done  = (r_state == ST_DONE);
  assign ready = (r_state != ST_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_work  <= 16'h0000;
      r_rem   <= 4'h0;
      r_op_q  <= 2'b00;
      out     <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_work <= in;
            r_rem  <= cnt;
            r_op_q <= op;
            if (cnt == 4'h0) begin
              // Zero count completes immediately; from DONE this keeps done high a second cycle.
              out     <= in;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SHIFT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == 4'h0) begin
            out     <= w_shifted;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [3:0]  dcnt;
  logic [1:0]  dop;
  logic [15:0] out;
  logic        done;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_out;

  shift_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (din),
    .cnt   (dcnt),
    .op    (dop),
    .out   (out),
    .done  (done),
    .ready (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  c;
    logic [1:0]  o;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: apply cnt single-bit moves, straight from the op definitions.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
    logic [15:0] v;
    v = a;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(c)) begin
        case (o)
          2'b00:   v = {v[14:0], v[15]};
          2'b01:   v = {v[14:0], 1'b0};
          2'b10:   v = {v[0], v[15:1]};
          default: v = {1'b0, v[15:1]};
        endcase
      end
    end
    return v;
  endfunction

  // Called 1 time unit after an edge while the DUT is ready; returns in the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        input logic [15:0] exp_out, input int exp_lat, input bit poke, input string nm);
    int cyc;
    int rlow;
    bit moved;
    logic [15:0] hold;
    hold  = prev_out;
    start = 1'b1; din = a; dcnt = c; dop = o;
    @(posedge clk); #1;
    start = 1'b0; din = $urandom; dcnt = 4'($urandom); dop = 2'($urandom);
    cyc = 1; rlow = 0; moved = 0;
    while (done !== 1'b1 && cyc <= 8) begin
      if (ready !== 1'b1) rlow++;
      if (out !== hold) moved = 1;
      if (poke && cyc == 1) begin
        start = 1'b1; din = 16'hFFFF; dcnt = 4'h0; dop = 2'b00;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({nm, " latency"}, cyc, exp_lat);
    check({nm, " out"}, out, exp_out);
    check({nm, " ready-low cycles"}, rlow, exp_lat - 1);
    check({nm, " ready in done"}, ready, 1'b1);
    if (exp_lat > 1) check({nm, " out held while shifting"}, moved, 0);
    prev_out = exp_out;
  endtask

  task automatic idle_step(input string nm);
    @(posedge clk); #1;
    check({nm, " done drops"}, done, 1'b0);
    check({nm, " idle ready"}, ready, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h8001, 4'd3,  2'b11, 16'h1000, 3};
    vecs[1] = '{16'h8001, 4'd4,  2'b00, 16'h0018, 2};
    vecs[2] = '{16'h0001, 4'd15, 2'b10, 16'h0002, 5};
    vecs[3] = '{16'hABCD, 4'd0,  2'b01, 16'hABCD, 1};
    vecs[4] = '{16'h1234, 4'd8,  2'b00, 16'h3412, 2};
    vecs[5] = '{16'hFFFF, 4'd15, 2'b11, 16'h0001, 5};
    vecs[6] = '{16'h0001, 4'd10, 2'b01, 16'h0400, 3};
    vecs[7] = '{16'h00FF, 4'd4,  2'b10, 16'hF00F, 2};

    rst = 1'b0; start = 1'b1; din = 16'h5555; dcnt = 4'h0; dop = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    check("reset out", out, 16'h0000);
    check("reset done", done, 1'b0);
    check("reset ready", ready, 1'b1);
    start = 1'b0;
    rst = 1'b1;
    prev_out = 16'h0000;
    @(posedge clk); #1;

    // Table vectors, each followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].c, vecs[i].o, vecs[i].exp_out, vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));
      idle_step($sformatf("vec%0d", i));
    end

    // Start during SHIFT is ignored; then back-to-back accept in the done cycle.
    run_op(16'h0003, 4'hF, 2'b01, 16'h8000, 5, 1'b1, "midstart");
    run_op(16'h00F0, 4'h4, 2'b11, 16'h000F, 2, 1'b0, "b2b");
    // Zero count accepted in the done cycle: done stays high with the new value.
    run_op(16'h1357, 4'h0, 2'b10, 16'h1357, 1, 1'b0, "zero-again");
    idle_step("zero-again");

    // Reset in the 2nd SHIFT cycle aborts the op without a done.
    begin
      int seen;
      start = 1'b1; din = 16'h00FF; dcnt = 4'hF; dop = 2'b00;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("abort out", out, 16'h0000);
      check("abort done", done, 1'b0);
      check("abort ready", ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1) seen++;
      end
      check("abort no done", seen, 0);
      prev_out = 16'h0000;
    end

    // Randomized sweep over every op/cnt pair, with random operand and random idle gaps.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 64; k++) begin
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;
        a = 16'($urandom);
        c = 4'(k);
        o = 2'(k >> 4);
        run_op(a, c, o, ref_shift(a, c, o), $countones(c) + 1, bit'($urandom_range(0, 1)),
               $sformatf("rnd op%0d cnt%0d", o, c));
        if ($urandom_range(0, 2) == 0) idle_step("rnd gap");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
